// File: rtl/spi_send_sched.sv
// ---------------------------------------------------------------------------
// spi_send_sched
// Byte scheduler between a first-word-fall-through send FIFO and an 8-bit SPI
// shift engine. It frames a transfer with slave select (one cycle CS setup and
// one cycle CS hold), pops one byte per shift, tolerates up to STALL_MAX empty
// FIFO cycles between bytes before aborting with a sticky underrun flag, and
// honours host aborts without cutting a byte mid-shift.
//
// Ports
//   clk         single clock, all state on the rising edge
//   reset       asynchronous active-high reset
//   start       one-cycle transfer request, sampled in IDLE only
//   xfer_len    transfer length in bytes (1..MAX_LEN), sampled with start
//   abort       host termination request
//   fifo_data   FIFO head byte (valid while fifo_empty is low)
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  one-cycle pop strobe
//   tr_start    one-cycle strobe to the shift engine
//   tr_data     byte for the shift engine, stable from tr_start to tr_done
//   tr_done     one-cycle pulse from the shift engine, byte shifted out
//   ss_n        active-low slave select
//   busy        high in every state except IDLE
//   done        one-cycle pulse at the end of every accepted transfer
//   underrun    sticky FIFO-starvation flag, cleared by the next accepted start
//   bytes_sent  bytes completed in the current or last transfer
// ---------------------------------------------------------------------------
module spi_send_sched #(
    parameter int unsigned STALL_MAX = 16,
    parameter int unsigned MAX_LEN   = 260
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] xfer_len,
    input  logic       abort,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    output logic       tr_start,
    output logic [7:0] tr_data,
    input  logic       tr_done,
    output logic       ss_n,
    output logic       busy,
    output logic       done,
    output logic       underrun,
    output logic [8:0] bytes_sent
);

    localparam int unsigned LEN_W   = 9;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned STALL_W = 8;

    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(STALL_MAX);
    localparam logic [LEN_W-1:0]   LEN_LIMIT   = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        FETCH,
        SHIFT,
        HOLD,
        FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    bytes_d, bytes_inc;
    logic [STALL_W-1:0]  stall_q, stall_d, stall_inc;
    logic                abort_pend_q, abort_pend_d;
    logic                underrun_d;
    logic [BYTE_W-1:0]   tr_data_d;
    logic                fifo_rd_en_d;
    logic                tr_start_d;
    logic                ss_n_d;
    logic                busy_d;
    logic                done_d;
    logic                start_ok;

    // A start is only honoured for a legal, non-zero length.
    assign start_ok = start && (xfer_len != '0) && (xfer_len <= LEN_LIMIT);

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            bytes_sent   <= '0;
            stall_q      <= '0;
            abort_pend_q <= 1'b0;
            underrun     <= 1'b0;
            tr_data      <= '0;
            fifo_rd_en   <= 1'b0;
            tr_start     <= 1'b0;
            ss_n         <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            bytes_sent   <= bytes_d;
            stall_q      <= stall_d;
            abort_pend_q <= abort_pend_d;
            underrun     <= underrun_d;
            tr_data      <= tr_data_d;
            fifo_rd_en   <= fifo_rd_en_d;
            tr_start     <= tr_start_d;
            ss_n         <= ss_n_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        bytes_d      = bytes_sent;
        stall_d      = stall_q;
        abort_pend_d = abort_pend_q;
        underrun_d   = underrun;
        tr_data_d    = tr_data;
        fifo_rd_en_d = 1'b0;
        tr_start_d   = 1'b0;
        bytes_inc    = bytes_sent + LEN_W'(1);
        stall_inc    = stall_q + STALL_W'(1);

        unique case (state_q)
            IDLE: begin
                // abort is deliberately ignored here, even alongside start.
                if (start_ok) begin
                    len_d        = xfer_len;
                    bytes_d      = '0;
                    stall_d      = '0;
                    abort_pend_d = 1'b0;
                    underrun_d   = 1'b0;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                state_d = abort ? HOLD : FETCH;
            end
            FETCH: begin
                if (abort) begin
                    state_d = HOLD;
                end else if (!fifo_empty) begin
                    // Strobes are registered; the FIFO only grows meanwhile,
                    // so the head captured here is still the one popped.
                    fifo_rd_en_d = 1'b1;
                    tr_start_d   = 1'b1;
                    tr_data_d    = fifo_data;
                    stall_d      = '0;
                    state_d      = SHIFT;
                end else begin
                    stall_d = stall_inc;
                    if (stall_inc == STALL_LIMIT) begin
                        underrun_d = 1'b1;
                        state_d    = HOLD;
                    end
                end
            end
            SHIFT: begin
                // An abort during a shift waits for the byte to finish.
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (tr_done) begin
                    bytes_d = bytes_inc;
                    if ((bytes_inc == len_q) || abort_pend_q || abort) begin
                        state_d = HOLD;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            HOLD: begin
                state_d = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Framing outputs follow the state being entered so they line up
        // with the registered state.
        ss_n_d = (state_d == IDLE) || (state_d == FINISH);
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

endmodule

// File: tb/tb_spi_send_sched.sv
module tb_spi_send_sched;

    localparam int unsigned STALL_MAX = 16;
    localparam int unsigned MAX_LEN   = 260;
    localparam int          BUDGET    = 4000;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [8:0] xfer_len;
    logic       abort;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic       tr_start;
    logic [7:0] tr_data;
    logic       tr_done;
    logic       ss_n;
    logic       busy;
    logic       done;
    logic       underrun;
    logic [8:0] bytes_sent;

    always #5 clk = ~clk;

    spi_send_sched #(
        .STALL_MAX(STALL_MAX),
        .MAX_LEN  (MAX_LEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .xfer_len  (xfer_len),
        .abort     (abort),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .tr_start  (tr_start),
        .tr_data   (tr_data),
        .tr_done   (tr_done),
        .ss_n      (ss_n),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun),
        .bytes_sent(bytes_sent)
    );

    // Environment: FIFO contents, shift-engine timing and per-transfer tallies.
    logic [7:0] fifo_q[$];
    logic [7:0] sent_log[$];
    int         tstart_log[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         lat_cfg = 8;
    int         done_at = -1;
    bit         feed    = 1'b0;
    int         cur_len = 0;
    int         pops    = 0;
    int         tstarts = 0;
    int         tdones  = 0;
    int         dones   = 0;
    int         last_tdone_cyc = 0;
    int         start_cyc      = 0;
    int         done_dist      = -1;
    bit         prev_tdone     = 1'b0;
    logic [7:0] held_byte      = 8'h00;
    int         exp_bytes      = 0;
    int         exp_dist       = 0;
    logic       exp_underrun   = 1'b0;
    bit         chk_dist       = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void fifo_sync();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
    endfunction

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_sync();
    endtask

    // Per-cycle comparison of DUT outputs against the environment's view.
    task automatic compare_cycle();
        check("ss_n_framing", int'(ss_n), int'(!(busy && !done)));
        check("bytes_bound", int'(int'(bytes_sent) <= cur_len), 1);
        if (fifo_rd_en || tr_start)
            check("pop_with_tr_start", int'(fifo_rd_en), int'(tr_start));
        if (fifo_rd_en) begin
            check("pop_nonempty", int'(fifo_empty), 0);
            if (fifo_q.size() > 0)
                check("tr_data_head", int'(tr_data), int'(fifo_q[0]));
        end
        if (tr_start)
            check("byte_spacing", cyc - last_tdone_cyc, 2);
        if (tr_done)
            check("tr_data_stable", int'(tr_data), int'(held_byte));
        if (prev_tdone)
            check("bytes_count", int'(bytes_sent), tdones);
        if (done) begin
            check("done_busy", int'(busy), 1);
            check("bytes_at_done", int'(bytes_sent), exp_bytes);
            check("underrun_at_done", int'(underrun), int'(exp_underrun));
            if (chk_dist)
                check("done_after_last_byte", cyc - last_tdone_cyc, exp_dist);
        end
    endtask

    task automatic model_update();
        if (done) begin
            dones++;
            done_dist = cyc - last_tdone_cyc;
        end
        if (fifo_rd_en && fifo_q.size() > 0) begin
            held_byte = fifo_q.pop_front();
            pops++;
        end
        if (tr_start) begin
            tstarts++;
            tstart_log.push_back(cyc);
            sent_log.push_back(tr_data);
            done_at = cyc + lat_cfg;
        end
        if (tr_done) begin
            tdones++;
            last_tdone_cyc = cyc;
        end
        if (feed && fifo_q.size() < 2)
            fifo_q.push_back(8'($urandom));
        fifo_sync();
        prev_tdone = tr_done;
    endtask

    // One clock: engine output for this cycle, compare, then model update.
    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
        tr_done = (done_at == cyc);
        compare_cycle();
        model_update();
        @(negedge clk);
    endtask

    task automatic begin_xfer(input int len, input int navail, input int lat, input bit feed_i,
                              input int abort_k, input bit start_abort);
        int avail;
        pops = 0; tstarts = 0; tdones = 0; dones = 0; done_dist = -1;
        sent_log.delete();
        tstart_log.delete();
        cur_len = len;
        lat_cfg = lat;
        feed    = feed_i;
        avail   = feed_i ? len : navail;
        if (abort_k > 0) begin
            exp_bytes = abort_k; exp_underrun = 1'b0; chk_dist = 1'b0;
        end else if (avail >= len) begin
            exp_bytes = len; exp_underrun = 1'b0; chk_dist = 1'b1; exp_dist = 2;
        end else begin
            exp_bytes = avail; exp_underrun = 1'b1; chk_dist = 1'b1;
            exp_dist = int'(STALL_MAX) + 2;
        end
        xfer_len = 9'(len);
        start    = 1'b1;
        abort    = start_abort;
        step();
        start = 1'b0;
        abort = 1'b0;
        start_cyc      = cyc;
        last_tdone_cyc = cyc;
    endtask

    task automatic run_xfer(input int len, input int navail, input int lat, input bit feed_i,
                            input int abort_k, input int abort_dly, input bit mid_start,
                            input bit start_abort);
        begin_xfer(len, navail, lat, feed_i, abort_k, start_abort);
        for (int i = 0; i < BUDGET && dones == 0; i++) begin
            abort = (abort_k > 0) && (tstart_log.size() >= abort_k) &&
                    (cyc == tstart_log[abort_k-1] + abort_dly);
            start = mid_start && (cyc == start_cyc + 4);
            if (start) xfer_len = 9'd1;
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        feed  = 1'b0;
        if (dones == 0) check("done_timeout", 0, 1);
        repeat (3) step();
        check("done_count", dones, 1);
        check("pop_count", pops, exp_bytes);
        check("busy_after", int'(busy), 0);
        check("ss_n_after", int'(ss_n), 1);
        check("bytes_hold", int'(bytes_sent), exp_bytes);
        check("underrun_hold", int'(underrun), int'(exp_underrun));
    endtask

    task automatic try_ignored(input int len, input bit with_abort, input bit with_start);
        dones = 0;
        xfer_len = 9'(len);
        start = with_start;
        abort = with_abort;
        step();
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ignored_busy", int'(busy), 0);
        end
        check("ignored_done", dones, 0);
        check("ignored_bytes", int'(bytes_sent), exp_bytes);
        check("ignored_underrun", int'(underrun), int'(exp_underrun));
    endtask

    task automatic reset_mid();
        int k;
        fifo_q.delete();
        for (int i = 0; i < 5; i++) push_byte(8'($urandom));
        begin_xfer(5, 5, 8, 1'b0, 0, 1'b0);
        k = 0;
        while (k < BUDGET && !(tstart_log.size() >= 3 && cyc == tstart_log[2] + 2)) begin
            step();
            k++;
        end
        if (k >= BUDGET) check("reset_reach_timeout", 0, 1);
        reset = 1'b1;
        #1;
        check("rst_ss_n", int'(ss_n), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_bytes", int'(bytes_sent), 0);
        check("rst_done", int'(done), 0);
        check("rst_tr_start", int'(tr_start), 0);
        done_at = -1;
        repeat (2) step();
        reset = 1'b0;
        repeat (4) step();
        check("rst_no_done", dones, 0);
        check("rst_no_pop", pops, 3);
        exp_bytes = 0;
        exp_underrun = 1'b0;
    endtask

    initial begin
        #800000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] lit [4];
        int len, mode, lat, navail, ak, ad;
        lit = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};

        reset = 1'b1; start = 1'b0; abort = 1'b0; xfer_len = '0; tr_done = 1'b0;
        fifo_sync();
        repeat (3) step();
        reset = 1'b0;
        step();
        check("reset_ss_n", int'(ss_n), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_underrun", int'(underrun), 0);
        check("reset_rd_en", int'(fifo_rd_en), 0);
        check("reset_tr_start", int'(tr_start), 0);
        check("reset_tr_data", int'(tr_data), 0);
        check("reset_bytes", int'(bytes_sent), 0);

        // Four preloaded bytes, engine latency 8.
        fifo_q.delete();
        for (int i = 0; i < 4; i++) push_byte(8'hA1 + 8'(i));
        run_xfer(4, 4, 8, 1'b0, 0, 0, 1'b0, 1'b0);
        check("seq_len", sent_log.size(), 4);
        for (int i = 0; i < 4 && i < sent_log.size(); i++)
            check("seq_byte", int'(sent_log[i]), int'(lit[i]));
        check("seq_bytes_lit", int'(bytes_sent), 4);
        check("seq_underrun_lit", int'(underrun), 0);

        // Starvation: two bytes for a five-byte transfer.
        fifo_q.delete();
        push_byte(8'h11);
        push_byte(8'h22);
        run_xfer(5, 2, 8, 1'b0, 0, 0, 1'b0, 1'b0);
        check("starve_bytes_lit", int'(bytes_sent), 2);
        check("starve_underrun_lit", int'(underrun), 1);
        check("starve_dist_lit", done_dist, 18);

        // Longest legal transfer with the FIFO kept fed.
        fifo_q.delete();
        run_xfer(260, 0, 2, 1'b1, 0, 0, 1'b0, 1'b0);
        check("max_pops_lit", pops, 260);
        check("max_tstarts_lit", tstarts, 260);
        check("max_bytes_lit", int'(bytes_sent), 260);

        // Out-of-range starts and a lone abort in IDLE are ignored.
        fifo_q.delete();
        push_byte(8'h55);
        try_ignored(0, 1'b0, 1'b1);
        try_ignored(261, 1'b0, 1'b1);
        try_ignored(511, 1'b0, 1'b1);
        try_ignored(3, 1'b1, 1'b0);

        // Abort three cycles after the second byte's tr_start.
        fifo_q.delete();
        for (int i = 0; i < 10; i++) push_byte(8'($urandom));
        run_xfer(10, 10, 8, 1'b0, 2, 3, 1'b0, 1'b0);
        check("abort_bytes_lit", int'(bytes_sent), 2);
        check("abort_pops_lit", pops, 2);

        // Start while busy, and start together with abort in IDLE.
        fifo_q.delete();
        for (int i = 0; i < 4; i++) push_byte(8'($urandom));
        run_xfer(4, 4, 8, 1'b0, 0, 0, 1'b1, 1'b1);
        check("busy_start_bytes_lit", int'(bytes_sent), 4);

        // Reset during the third byte's shift, then a clean one-byte transfer.
        reset_mid();
        fifo_q.delete();
        push_byte(8'h5A);
        run_xfer(1, 1, 8, 1'b0, 0, 0, 1'b0, 1'b0);
        check("post_reset_byte_lit", (sent_log.size() > 0) ? int'(sent_log[0]) : -1, 8'h5A);

        // Randomized transfers: full supply, starvation or mid-transfer abort.
        for (int t = 0; t < 14; t++) begin
            len  = int'($urandom_range(1, 12));
            mode = int'($urandom_range(0, 2));
            lat  = int'($urandom_range(1, 10));
            ak   = 0;
            ad   = 0;
            if (mode == 2 && len < 2) mode = 0;
            case (mode)
                0:       navail = len + int'($urandom_range(0, 2));
                1:       navail = int'($urandom_range(0, len - 1));
                default: begin
                    navail = len;
                    ak     = int'($urandom_range(1, len - 1));
                    ad     = int'($urandom_range(1, lat + 1));
                end
            endcase
            fifo_q.delete();
            for (int i = 0; i < navail; i++) push_byte(8'($urandom));
            run_xfer(len, navail, lat, 1'b0, ak, ad, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_send_sched.md
SPI_SEND_SCHED -- requirements
Module: spi_send_sched

Interface
REQ-001 Parameter: STALL_MAX, 16, FIFO-empty cycles tolerated mid-transfer before abort (1..255).
REQ-002 Parameter: MAX_LEN, 260, largest legal transfer length in bytes.
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 Port: start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-006 Port: xfer_len  input  9  byte count for the transfer, sampled with start.
REQ-007 Port: abort  input  1  host-requested termination, sampled every cycle.
REQ-008 Port: fifo_data  input  8  send-FIFO head byte, first-word-fall-through (valid whenever fifo_empty=0).
REQ-009 Port: fifo_empty  input  1  send-FIFO empty flag.
REQ-010 Port: fifo_rd_en  output  1  one-cycle pop strobe to send FIFO.
REQ-011 Port: tr_start  output  1  one-cycle strobe to the 8-bit shift engine.
REQ-012 Port: tr_data  output  8  byte presented to shift engine, stable from tr_start until tr_done.
REQ-013 Port: tr_done  input  1  one-cycle pulse from shift engine: current byte shifted out.
REQ-014 Port: ss_n  output  1  flash slave select, active-low.
REQ-015 Port: busy  output  1  high in every state except IDLE.
REQ-016 Port: done  output  1  one-cycle pulse at transfer end (normal or abort).
REQ-017 Port: underrun  output  1  sticky error: transfer aborted on FIFO starvation; cleared by next accepted start.
REQ-018 Port: bytes_sent  output  9  count of bytes completed in current/last transfer.

Function
REQ-019 States SHALL be IDLE, SETUP, FETCH, SHIFT, HOLD, FINISH; encoding free.
REQ-020 IDLE: start=1 with 1<=xfer_len<=MAX_LEN SHALL latch xfer_len, clear bytes_sent and underrun, go SETUP; out-of-range start SHALL be ignored (no busy, no done).
REQ-021 SETUP: ss_n SHALL go low on entry; one cycle later go FETCH (1-cycle CS setup).
REQ-022 FETCH with fifo_empty=0: same cycle assert fifo_rd_en and tr_start for exactly one cycle, register fifo_data into tr_data, go SHIFT.
REQ-023 FETCH with fifo_empty=1: stay, increment stall counter; stall counter SHALL reset to 0 on every pop.
REQ-024 Stall counter reaching STALL_MAX SHALL set underrun=1 and go HOLD.
REQ-025 SHIFT: wait for tr_done; on tr_done bytes_sent increments; if new bytes_sent == latched length go HOLD, else go FETCH.
REQ-026 Minimum byte-to-byte spacing: tr_done cycle -> FETCH -> tr_start next cycle (no pop in the tr_done cycle).
REQ-027 HOLD: ss_n stays low one cycle (CS hold), go FINISH.
REQ-028 FINISH: ss_n high, done=1 for one cycle, go IDLE; busy low from the IDLE cycle on.
REQ-029 abort=1 in SETUP or FETCH SHALL go HOLD immediately; in SHIFT SHALL be remembered and take effect on tr_done (byte never cut mid-shift); underrun unaffected.
REQ-030 start while busy SHALL be ignored; abort in IDLE SHALL have no effect.
REQ-031 fifo_rd_en SHALL never assert while fifo_empty=1; exactly one pop per tr_start.
REQ-032 bytes_sent SHALL never exceed latched length; holds value after done until next accepted start.

Reset
REQ-033 reset=1 at any time SHALL asynchronously force IDLE, ss_n=1, busy=0, done=0, underrun=0, fifo_rd_en=0, tr_start=0, tr_data=0, bytes_sent=0, stall counter=0.
REQ-034 Reset mid-transfer SHALL not pop further bytes; no done pulse is generated for the interrupted transfer.

Verification
REQ-035 FIFO preloaded 4 bytes 0xA1..0xA4, start len=4, shift engine tr_done 8 cycles after tr_start -> 4 pops, tr_data sequence A1..A4, bytes_sent=4, one done, ss_n low from SETUP to HOLD, underrun=0.
REQ-036 FIFO holds 2 bytes, len=5, STALL_MAX=16 -> 2 bytes sent, 16 stall cycles in FETCH, underrun=1, done once, bytes_sent=2, ss_n high after FINISH.
REQ-037 len=260 with FIFO kept non-empty -> exactly 260 tr_start/fifo_rd_en pulses, bytes_sent=260; len=0 and len=261 -> ignored, busy stays 0.
REQ-038 abort asserted 3 cycles after tr_start of byte 2 of len=10 -> byte 2 completes, bytes_sent=2, no third pop, done pulses, underrun=0.
REQ-039 reset asserted during SHIFT of byte 3 -> same-cycle ss_n=1, busy=0, bytes_sent=0, no done; subsequent start len=1 completes normally.
REQ-040 start pulsed while busy and simultaneous start/abort in IDLE -> busy transfer unaffected; new transfer begins per start only.
